// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - single-outstanding AXI4-Lite master driven by a cmd/rsp stream
module axi_lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_AW_W, S_WR_B, S_RD_AR, S_RD_R, S_RSP
    } state_t;

    state_t                         r_state,       w_state_nxt;
    logic                           r_cmd_ready,   w_cmd_ready_nxt;
    logic                           r_awvalid,     w_awvalid_nxt;
    logic                           r_wvalid,      w_wvalid_nxt;
    logic                           r_bready,      w_bready_nxt;
    logic                           r_arvalid,     w_arvalid_nxt;
    logic                           r_rready,      w_rready_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0]  r_addr,        w_addr_nxt;
    logic [C_M_AXI_DATA_WIDTH-1:0]  r_wdata,       w_wdata_nxt;
    logic [SW-1:0]                  r_wstrb,       w_wstrb_nxt;
    logic                           r_rsp_valid,   w_rsp_valid_nxt;
    logic [C_M_AXI_DATA_WIDTH-1:0]  r_rsp_rdata,   w_rsp_rdata_nxt;
    logic [1:0]                     r_rsp_resp,    w_rsp_resp_nxt;
    logic                           r_rsp_timeout, w_rsp_timeout_nxt;
    logic [CW-1:0]                  r_cnt,         w_cnt_nxt;
    logic [CW-1:0]                  w_cnt_inc;
    logic                           w_expired;

    // The limit is judged on the incremented count so that the response
    // appears TIMEOUT_CYCLES cycles after the command handshake. A phase
    // handshake at the limit still advances; the next phase then expires
    // on its first cycle unless it also completes.
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_expired = (w_cnt_inc >= CW'(TIMEOUT_CYCLES - 1));

    // State and registered outputs
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_awvalid     <= w_awvalid_nxt;
            r_wvalid      <= w_wvalid_nxt;
            r_bready      <= w_bready_nxt;
            r_arvalid     <= w_arvalid_nxt;
            r_rready      <= w_rready_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_wstrb       <= w_wstrb_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_resp    <= w_rsp_resp_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt       = r_state;
        w_awvalid_nxt     = r_awvalid;
        w_wvalid_nxt      = r_wvalid;
        w_bready_nxt      = r_bready;
        w_arvalid_nxt     = r_arvalid;
        w_rready_nxt      = r_rready;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;
        w_wstrb_nxt       = r_wstrb;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_resp_nxt    = r_rsp_resp;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_cnt_nxt         = r_cnt;
        w_cmd_ready_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_cmd_ready && cmd_valid) begin
                    w_addr_nxt  = cmd_addr;
                    w_wdata_nxt = cmd_wdata;
                    w_wstrb_nxt = cmd_wstrb;
                    w_cnt_nxt   = '0;
                    if (cmd_write) begin
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = S_WR_AW_W;
                    end else begin
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = S_RD_AR;
                    end
                end
            end
            S_WR_AW_W: begin
                w_cnt_nxt     = w_cnt_inc;
                w_awvalid_nxt = r_awvalid && !M_AXI_AWREADY;
                w_wvalid_nxt  = r_wvalid && !M_AXI_WREADY;
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = S_WR_B;
                end else if (w_expired) begin
                    w_awvalid_nxt     = 1'b0;
                    w_wvalid_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_resp_nxt    = 2'b10;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_state_nxt       = S_RSP;
                end
            end
            S_WR_B: begin
                w_cnt_nxt = w_cnt_inc;
                if (M_AXI_BVALID) begin
                    w_bready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_resp_nxt    = M_AXI_BRESP;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_rdata_nxt   = '0;
                    w_state_nxt       = S_RSP;
                end else if (w_expired) begin
                    w_bready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_resp_nxt    = 2'b10;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_state_nxt       = S_RSP;
                end
            end
            S_RD_AR: begin
                w_cnt_nxt = w_cnt_inc;
                if (M_AXI_ARREADY) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RD_R;
                end else if (w_expired) begin
                    w_arvalid_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_resp_nxt    = 2'b10;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_state_nxt       = S_RSP;
                end
            end
            S_RD_R: begin
                w_cnt_nxt = w_cnt_inc;
                if (M_AXI_RVALID) begin
                    w_rready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_resp_nxt    = M_AXI_RRESP;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_rdata_nxt   = M_AXI_RDATA;
                    w_state_nxt       = S_RSP;
                end else if (w_expired) begin
                    w_rready_nxt      = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_resp_nxt    = 2'b10;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_state_nxt       = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Accepting only while idle keeps a single transaction outstanding.
        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;
endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- Single-outstanding AXI4-Lite master that turns a simple command/response stream into AXI4-Lite read and write transactions.
- Sits directly upstream of the AXI register file: the PCIe/host command logic drives the cmd port, and the M_AXI port connects to the register file slave port.
- Adds a per-transaction timeout so that an unresponsive slave cannot hang the command path.

Parameters:
- C_M_AXI_ADDR_WIDTH, 4, AXI address width (matches the register file default).
- C_M_AXI_DATA_WIDTH, 32, AXI data width; 32 or 64 only.
- TIMEOUT_CYCLES, 1024, cycles allowed from transaction start to B/R handshake; minimum 4.

Ports:
- M_AXI_ACLK  in  1  clock for all logic.
- M_AXI_ARESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  AXI BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  transaction timed out.
- M_AXI_AWADDR, AWPROT(3), AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP(2), BVALID, BREADY, ARADDR, ARPROT(3), ARVALID, ARREADY, RDATA, RRESP(2), RVALID, RREADY: standard AXI4-Lite master signals.

Behaviour:
- Reset values (any cycle with M_AXI_ARESET=1): state=IDLE; all M_AXI valids and readies 0; addresses, data and strobes 0; cmd_ready=0; rsp_valid=0; rsp_rdata=0; rsp_resp=0; rsp_timeout=0; timeout counter 0.
- Reset mid-transaction aborts immediately, with no response and all valids dropped.
- AWPROT and ARPROT are constant 3'b000.
- cmd_ready=1 only in IDLE, as a registered output.
- States and transitions:
  - IDLE: on a cmd handshake, register addr/wdata/wstrb and clear the counter.
    - Write: assert AWVALID and WVALID in the same next cycle, then go to WR_AW_W.
    - Read: assert ARVALID, then go to RD_AR.
  - WR_AW_W:
    - Drop AWVALID on the AWVALID&&AWREADY cycle.
    - Drop WVALID on the WVALID&&WREADY cycle.
    - The two handshakes may occur in the same cycle or in different cycles, in either order.
    - AW and W are always presented together because the slave requires both valids before it asserts ready.
    - When both handshakes are done, assert BREADY and go to WR_B.
  - WR_B: on BVALID&&BREADY, capture BRESP, drop BREADY, set rsp_rdata=0, go to RSP.
  - RD_AR: on ARVALID&&ARREADY, drop ARVALID, assert RREADY, go to RD_R.
  - RD_R: on RVALID&&RREADY, capture RDATA and RRESP, drop RREADY, go to RSP.
  - RSP: rsp_valid=1 and response fields held stable. On rsp_ready, clear rsp_valid and go to IDLE. cmd_ready rises in the cycle after the rsp handshake.
- Payload stability: while any VALID is asserted, address, data and strobe are held stable.
- Timeout counter:
  - Increments each cycle in WR_AW_W, WR_B, RD_AR and RD_R.
  - When it reaches TIMEOUT_CYCLES-1 without completion: drop all valids and readies, set rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0, go to RSP.
  - A handshake that completes in the same cycle the counter hits its limit takes priority, and the normal response is reported.
- Latency against a zero-wait slave:
  - Write: cmd handshake at cycle 0; AW/W valid at cycle 1; B handshake at cycle 2 or later, depending on the slave; rsp_valid in the cycle after the B handshake.
  - Read: same shape, with the R handshake in place of B.
- Only one transaction is outstanding at a time; there is no pipelining.

Test Plan:
- Write with cmd_addr=0x8, wdata=0xDEADBEEF, wstrb=0xF to a register file slave, then a read at 0x8 -> AW and W valid in the same cycle; rsp_resp=0 and rsp_timeout=0 for both; read rsp_rdata=0xDEADBEEF.
- Write 0x11223344 wstrb=0x5 to 0x4 after a prior 0xFFFFFFFF, then a read -> rdata=0xFF22FF44.
- Slave model with WREADY one cycle before AWREADY, then the reverse order -> each valid drops independently, exactly one B is accepted, rsp_valid asserts once.
- Slave never asserts ARREADY, TIMEOUT_CYCLES=16 -> ARVALID drops and rsp_valid asserts 16 cycles after the cmd handshake, with rsp_resp=2'b10, rsp_timeout=1, rdata=0; the next command is accepted normally.
- rsp_ready held 0 for 5 cycles -> rsp fields stable, cmd_ready=0 throughout; cmd_ready=1 in the cycle after the rsp handshake.
- Assert M_AXI_ARESET in WR_B -> next cycle all outputs at their reset values and no rsp_valid; a subsequent read completes correctly.
